// File: rtl/quiz_turn_arbiter.sv
// quiz_turn_arbiter: two-player buzzer arbiter and answer-turn sequencer.
// Opens a buzz window after the question is shown, grants one answer turn at a
// time, counts down each window in seconds, locks out wrong/timed-out players
// and keeps saturating BCD scores.
// Optional feature macro: QUIZ_ROTATE_PRIORITY_EN -- round-robin tie-break for
// simultaneous buzzes (otherwise player A always wins a tie).
module quiz_turn_arbiter #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int ANSWER_SEC = 9,
   parameter int OPEN_SEC   = 9
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       round_start_i,
   input  logic       abort_i,
   input  logic [1:0] buzz_i,
   input  logic       judge_valid_i,
   input  logic       judge_ok_i,
   input  logic       score_clr_i,
   output logic [2:0] state_o,
   output logic [1:0] grant_o,
   output logic [1:0] lock_o,
   output logic [3:0] time_left_o,
   output logic       round_done_o,
   output logic [1:0] winner_o,
   output logic [3:0] score_a_o,
   output logic [3:0] score_b_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OPEN   = 3'd1,
      S_ANSWER = 3'd2,
      S_DONE   = 3'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic [1:0]      lock_q, lock_d;
   logic [3:0]      time_q, time_d;
   logic [1:0]      winner_q, winner_d;
   logic            round_done_q;
   logic [3:0]      score_a_q, score_b_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            active, tick, expire;
   logic [1:0]      valid_buzz;
   logic            inc_a, inc_b;
`ifdef QUIZ_ROTATE_PRIORITY_EN
   logic            ptr_q, ptr_d;  // 0 = A preferred on a tie, 1 = B
`endif

   assign active     = (state_q == S_OPEN) || (state_q == S_ANSWER);
   assign tick       = active && (cnt_q == CW'(TICK_DIV - 1));
   assign expire     = tick && (time_q == 4'd1);
   assign valid_buzz = buzz_i & ~lock_q;

   // Next-state, turn, lockout and countdown decisions; abort overrides all.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      lock_d   = lock_q;
      time_d   = time_q;
      winner_d = winner_q;
      inc_a    = 1'b0;
      inc_b    = 1'b0;
`ifdef QUIZ_ROTATE_PRIORITY_EN
      ptr_d    = ptr_q;
`endif
      if (abort_i && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         grant_d  = 2'b00;
         lock_d   = 2'b00;
         time_d   = 4'd0;
         winner_d = 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (round_start_i) begin
                  state_d  = S_OPEN;
                  grant_d  = 2'b00;
                  lock_d   = 2'b00;
                  winner_d = 2'b00;
                  time_d   = 4'(OPEN_SEC);
               end
            end
            S_OPEN: begin
               // A buzz landing on the expiry edge still takes the turn.
               if (valid_buzz != 2'b00) begin
                  state_d = S_ANSWER;
                  time_d  = 4'(ANSWER_SEC);
                  if (valid_buzz == 2'b11) begin
`ifdef QUIZ_ROTATE_PRIORITY_EN
                     grant_d = ptr_q ? 2'b10 : 2'b01;
                     ptr_d   = ~ptr_q;
`else
                     grant_d = 2'b01;
`endif
                  end else begin
                     grant_d = valid_buzz;
                  end
               end else if (expire) begin
                  state_d  = S_DONE;
                  time_d   = 4'd0;
                  winner_d = 2'b00;
               end else if (tick) begin
                  time_d = time_q - 4'd1;
               end
            end
            S_ANSWER: begin
               if (judge_valid_i && judge_ok_i) begin
                  state_d  = S_DONE;
                  winner_d = grant_q;
                  inc_a    = grant_q[0];
                  inc_b    = grant_q[1];
                  grant_d  = 2'b00;
                  time_d   = 4'd0;
               end else if (judge_valid_i || expire) begin
                  lock_d  = lock_q | grant_q;
                  grant_d = 2'b00;
                  if (lock_d != 2'b11) begin
                     state_d = S_OPEN;
                     time_d  = 4'(OPEN_SEC);
                  end else begin
                     state_d  = S_DONE;
                     time_d   = 4'd0;
                     winner_d = 2'b00;
                  end
               end else if (tick) begin
                  time_d = time_q - 4'd1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Seconds prescaler: restarts on every window entry, wraps on each tick.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!active || (state_d != state_q) || tick) begin
         cnt_d = '0;
      end
   end

   // Round state registers; ROUND_DONE is high exactly while DONE is shown.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         grant_q      <= 2'b00;
         lock_q       <= 2'b00;
         time_q       <= 4'd0;
         winner_q     <= 2'b00;
         round_done_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lock_q       <= lock_d;
         time_q       <= time_d;
         winner_q     <= winner_d;
         round_done_q <= (state_d == S_DONE);
         cnt_q        <= cnt_d;
      end
   end

   // Saturating scores; a clear beats a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || score_clr_i) begin
         score_a_q <= 4'd0;
         score_b_q <= 4'd0;
      end else begin
         if (inc_a && (score_a_q != 4'd9)) score_a_q <= score_a_q + 4'd1;
         if (inc_b && (score_b_q != 4'd9)) score_b_q <= score_b_q + 4'd1;
      end
   end

`ifdef QUIZ_ROTATE_PRIORITY_EN
   // Tie-break pointer: starts at A, flips after every tie grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end
`endif

   assign state_o      = state_q;
   assign grant_o      = grant_q;
   assign lock_o       = lock_q;
   assign time_left_o  = time_q;
   assign round_done_o = round_done_q;
   assign winner_o     = winner_q;
   assign score_a_o    = score_a_q;
   assign score_b_o    = score_b_q;

endmodule

// File: tb/tb_quiz_turn_arbiter.sv
// Scoreboard bench for quiz_turn_arbiter: the driver steps a cycle-level
// reference model and queues the expected outputs; the monitor compares them.
module tb_quiz_turn_arbiter;

   localparam int TD  = 4;
   localparam int ANS = 3;
   localparam int OPN = 5;

   logic       clk = 1'b0;
   logic       rst, rs, ab, jv, jo, sc;
   logic [1:0] bz;
   logic [2:0] state;
   logic [1:0] grant, lock, winner;
   logic [3:0] tl, sa, sb;
   logic       rd;

   quiz_turn_arbiter #(.TICK_DIV(TD), .ANSWER_SEC(ANS), .OPEN_SEC(OPN)) dut (
      .clk_i(clk), .rst_i(rst), .round_start_i(rs), .abort_i(ab), .buzz_i(bz),
      .judge_valid_i(jv), .judge_ok_i(jo), .score_clr_i(sc),
      .state_o(state), .grant_o(grant), .lock_o(lock), .time_left_o(tl),
      .round_done_o(rd), .winner_o(winner), .score_a_o(sa), .score_b_o(sb)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] gr;
      logic [1:0] lk;
      logic [3:0] tl;
      logic       rd;
      logic [1:0] win;
      logic [3:0] sa;
      logic [3:0] sb;
   } out_t;

   out_t expq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: state 0..3, window length in seconds and cycles since
   // window entry; remaining time is derived arithmetically from the age.
   int m_st, m_gr, m_lk, m_win, m_sa, m_sb, m_ptr, m_age, m_len;

   function automatic out_t model_step(input bit r, s, a, input bit [1:0] b,
                                       input bit v, o, c);
      out_t e;
      bit   expd;
      int   vb;
      int   ia = 0, ib = 0;
      if (r) begin
         m_st = 0; m_gr = 0; m_lk = 0; m_win = 0; m_sa = 0; m_sb = 0;
         m_ptr = 0; m_age = 0; m_len = 0;
      end else begin
         expd = (m_st == 1 || m_st == 2) && (m_age + 1 == m_len * TD);
         if (a && m_st != 0) begin
            m_st = 0; m_gr = 0; m_lk = 0; m_win = 0;
         end else begin
            case (m_st)
               0: if (s) begin
                     m_st = 1; m_gr = 0; m_lk = 0; m_win = 0; m_len = OPN; m_age = 0;
                  end
               1: begin
                     vb = int'(b) & ~m_lk & 3;
                     if (vb != 0) begin
                        if (vb == 3) begin
`ifdef QUIZ_ROTATE_PRIORITY_EN
                           m_gr  = (m_ptr == 0) ? 1 : 2;
                           m_ptr = 1 - m_ptr;
`else
                           m_gr = 1;
`endif
                        end else m_gr = vb;
                        m_st = 2; m_len = ANS; m_age = 0;
                     end else if (expd) begin
                        m_st = 3; m_win = 0;
                     end else m_age++;
                  end
               2: begin
                     if (v && o) begin
                        m_win = m_gr; ia = (m_gr == 1); ib = (m_gr == 2);
                        m_gr = 0; m_st = 3;
                     end else if (v || expd) begin
                        m_lk = m_lk | m_gr; m_gr = 0;
                        if (m_lk != 3) begin
                           m_st = 1; m_len = OPN; m_age = 0;
                        end else begin
                           m_st = 3; m_win = 0;
                        end
                     end else m_age++;
                  end
               default: m_st = 0;
            endcase
         end
         if (c) begin
            m_sa = 0; m_sb = 0;
         end else begin
            if (ia != 0 && m_sa < 9) m_sa++;
            if (ib != 0 && m_sb < 9) m_sb++;
         end
      end
      e.st  = 3'(m_st);
      e.gr  = 2'(m_gr);
      e.lk  = 2'(m_lk);
      e.tl  = (m_st == 1 || m_st == 2) ? 4'(m_len - m_age / TD) : 4'd0;
      e.rd  = (m_st == 3);
      e.win = 2'(m_win);
      e.sa  = 4'(m_sa);
      e.sb  = 4'(m_sb);
      return e;
   endfunction

   task automatic drive(input bit r, s, a, input bit [1:0] b, input bit v, o, c);
      @(posedge clk);
      #2;
      rst = r; rs = s; ab = a; bz = b; jv = v; jo = o; sc = c;
      expq.push_back(model_step(r, s, a, b, v, o, c));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00, 0, 0, 0);
   endtask

   // Monitor: one expected snapshot per cycle, compared 1 time unit after the edge.
   initial begin : mon
      out_t e, act;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e   = expq.pop_front();
            act = '{st: state, gr: grant, lk: lock, tl: tl, rd: rd, win: winner, sa: sa, sb: sb};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs @%0t got st=%0d gr=%b lk=%b tl=%0d rd=%b win=%b sa=%0d sb=%0d want st=%0d gr=%b lk=%b tl=%0d rd=%b win=%b sa=%0d sb=%0d",
                        $time, act.st, act.gr, act.lk, act.tl, act.rd, act.win, act.sa, act.sb,
                        e.st, e.gr, e.lk, e.tl, e.rd, e.win, e.sa, e.sb);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; rs = 1'b0; ab = 1'b0; bz = 2'b00; jv = 1'b0; jo = 1'b0; sc = 1'b0;
      expq.push_back(model_step(1, 0, 0, 2'b00, 0, 0, 0));
      // reset then buzz while idle
      drive(0, 0, 0, 2'b01, 0, 0, 0);
      idle(2);
      // single winner B
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      idle(1);
      drive(0, 0, 0, 2'b10, 0, 0, 0);
      idle(2);
      drive(0, 0, 0, 2'b00, 1, 1, 0);
      idle(3);
      // wrong answer by A, then simultaneous buzz goes to B
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 0, 0, 2'b01, 0, 0, 0);
      drive(0, 0, 0, 2'b00, 1, 0, 0);
      drive(0, 0, 0, 2'b11, 0, 0, 0);
      drive(0, 0, 0, 2'b00, 1, 0, 0);
      idle(3);
      // A times out, window then expires with nobody granted
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 0, 0, 2'b01, 0, 0, 0);
      idle(36);
      // two tie rounds
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 0, 2'b00, 0, 0, 0);
         drive(0, 0, 0, 2'b11, 0, 0, 0);
         drive(0, 0, 0, 2'b00, 1, 1, 0);
         idle(2);
      end
      // correct verdict on the expiry edge
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 0, 0, 2'b01, 0, 0, 0);
      idle(11);
      drive(0, 0, 0, 2'b00, 1, 1, 0);
      idle(2);
      // drive A's score into saturation
      for (int k = 0; k < 10; k++) begin
         drive(0, 1, 0, 2'b00, 0, 0, 0);
         drive(0, 0, 0, 2'b01, 0, 0, 0);
         drive(0, 0, 0, 2'b00, 1, 1, 0);
         idle(1);
      end
      // abort during an answer turn
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 0, 0, 2'b10, 0, 0, 0);
      drive(0, 0, 1, 2'b00, 0, 0, 0);
      idle(2);
      // score clear racing an increment
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 0, 0, 2'b10, 0, 0, 0);
      drive(0, 0, 0, 2'b00, 1, 1, 1);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         drive($urandom_range(1999) == 0, $urandom_range(3) == 0, $urandom_range(199) == 0,
               {$urandom_range(5) == 0, $urandom_range(5) == 0},
               $urandom_range(4) == 0, $urandom_range(2) != 0, $urandom_range(999) == 0);
      end
      idle(1);
      @(posedge clk);
      #3;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
